axi_lite_regfile: RTL and testbench
===================================

# axi_lite_regfile

AXI4-Lite slave register file that terminates the master port of the AXI4-Lite data-width converter. It exposes `NumRegs` data-width registers to the fabric and drives their contents as flat outputs to the surrounding logic. Each register supports byte-strobed writes and has a one-cycle write pulse. Write and read paths are independent: each channel is buffered, and responses are registered.

## Interface
- `AxiAddrWidth`, 32, address width of `slv_req_i.aw/ar.addr`.
- `AxiDataWidth`, 32, register and data width; must be 32 or 64.
- `NumRegs`, 8, number of registers; ≥1.
- `axi_lite_req_t`, logic, AXI4-Lite request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
- `axi_lite_res_t`, logic, AXI4-Lite response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).
- `clk_i`  in  1  clock, rising edge; the block has one clock.
- `rst_i`  in  1  reset; asynchronous and active-high.
- `slv_req_i`  in  axi_lite_req_t  requests from upstream.
- `slv_res_o`  out  axi_lite_res_t  responses to upstream.
- `reg_q_o`  out  NumRegs×AxiDataWidth  current register contents, packed with index 0 at the LSBs.
- `reg_wr_o`  out  NumRegs  one-cycle pulse per register on commit; asserted even with zero strobes.

## Operation
- Decode: `StrbW = AxiDataWidth/8`. Register index = `addr >> log2(StrbW)`. Low offset bits are ignored. Index ≥ NumRegs is out of range.
- Write path:
  - Two one-entry slots, AW and W; `aw_ready = !aw_full` and `w_ready = !w_full`.
  - AW and W are accepted in any order or cycle.
  - Commit condition: `aw_full && w_full && !b_valid`.
  - On commit:
    - Each byte whose strobe is set updates the register.
    - Both slots are cleared.
    - `reg_wr_o[idx]` pulses for one cycle.
    - `b_valid` is set with `b.resp` = OKAY, or SLVERR per Configuration.
  - `b_valid` clears on `b_ready`.
- Read path:
  - `ar_ready = !r_valid`.
  - On AR handshake, `r.data` is registered from `reg_q` (pre-commit value in that cycle), and `r.resp` is set; `r_valid` is set.
  - `r.data`/`r.resp` are held stable until `r_ready`.
- Simultaneous read and write commit to the same register: the read returns the old value.
- Out-of-range write: no register changes and no pulse.
- Out-of-range read: data 0.
- Write FSM states:
  - COLLECT: slots filling.
  - COMMIT: both slots full; commit occurs this edge if `!b_valid`.
  - RESP: `b_valid` high.
  - Transitions: COLLECT→COMMIT when both slots are full. COMMIT→RESP on commit. RESP→COLLECT on `b_ready`. Slots may refill while in RESP.
- Reset values:
  - `aw_ready`, `w_ready`, `ar_ready` = 1.
  - `b_valid`, `r_valid` = 0.
  - `b.resp`, `r.resp`, `r.data` = 0.
  - `reg_q_o` = 0.
  - `reg_wr_o` = 0.
- Reset mid-operation clears the slots, pending B/R and all registers immediately. Any in-flight transactions are dropped.

## Timing
- AW and W handshakes in cycle N: commit at the end of N+1; `b_valid` and `reg_wr_o` high in N+2; `reg_q_o` updated in N+2.
- AR handshake in cycle N: `r_valid` high in N+1.
- Maximum throughput: one write per 2 cycles and one read per 2 cycles, with ready held high.
- No combinational path from any `*_valid` to any `*_ready`; all response outputs are registered.

## Configuration
- `AXI_LITE_REGFILE_SLVERR_EN` defined: out-of-range reads and writes return `resp` = SLVERR (2'b10).
- Undefined: all accesses return OKAY; out-of-range writes are silently dropped and out-of-range reads return 0.

## Structure
- Package `axi_lite_regfile_pkg`:
  - Response constants `RESP_OKAY` = 2'b00 and `RESP_SLVERR` = 2'b10.
  - Write FSM state enum `wr_state_e`.
  - Function `idx_width(NumRegs)` = `max(1, $clog2(NumRegs))`.
- Sub-module `axi_lite_regfile_slot`: parameterised one-entry holding register (valid/ready in, full flag and data out, clear input), instantiated for AW and W.

## Test plan
- Write 0x04 with data 0xDEADBEEF and strb 0xF, AW and W in the same cycle -> B OKAY two cycles later; `reg_q_o[1]` = 0xDEADBEEF; `reg_wr_o[1]` pulses one cycle.
- Then write 0x04 with data 0x00001234 and strb 0x3 -> `reg_q_o[1]` = 0xDEAD1234; read 0x04 returns 0xDEAD1234 with OKAY.
- W issued 3 cycles before AW (addr 0x08, data 0xA5A5A5A5) -> `w_ready` low while the slot is full; commit follows AW; `reg_q_o[2]` = 0xA5A5A5A5.
- Write and read of 0x40 (out of range) -> SLVERR with the macro, OKAY without; read data = 0; no `reg_q_o` or `reg_wr_o` change.
- Read 0x04 with `r_ready` held low 5 cycles -> `r_valid` and data stay stable; `ar_ready` = 0 throughout; a same-cycle write commit to reg 1 does not alter the pending R data.
- Assert `rst_i` with W held in its slot and `b_valid` high -> `b_valid` = 0, all `reg_q_o` = 0, and readies = 1 immediately; no B is issued after release.

Source files
------------

// File: rtl/axi_lite_regfile_pkg.sv
// Shared definitions for the AXI4-Lite register file: response codes,
// write-path FSM states, index-width helper and default 32-bit channel structs.
package axi_lite_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_COLLECT = 2'd0,
    WR_COMMIT  = 2'd1,
    WR_RESP    = 2'd2
  } wr_state_e;

  // Register-index width; never zero so a single-register file still has a port.
  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Default AXI4-Lite channel structs for a 32-bit address / 32-bit data bus.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } res_t;

endpackage

// File: rtl/axi_lite_regfile_slot.sv
// One-entry holding register: accepts data while empty, keeps it until cleared.
module axi_lite_regfile_slot
  import axi_lite_regfile_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [Width-1:0] data,
  input  logic             clear,
  output logic             ready,
  output logic             full,
  output logic [Width-1:0] q
);

  logic             full_reg;
  logic [Width-1:0] data_reg;

  // Fill on handshake, empty on clear; clear only happens while full so the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (valid && !full_reg) begin
      full_reg <= 1'b1;
      data_reg <= data;
    end
  end

  assign ready = !full_reg;
  assign full  = full_reg;
  assign q     = data_reg;

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with byte-strobed writes and per-register write pulses.
// Optional feature: define AXI_LITE_REGFILE_SLVERR_EN to answer out-of-range accesses
// with SLVERR instead of OKAY.
module axi_lite_regfile
  import axi_lite_regfile_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 32,
  parameter int unsigned NumRegs      = 8,
  parameter type axi_lite_req_t = req_t,
  parameter type axi_lite_res_t = res_t
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  axi_lite_req_t                   slv_req_i,
  output axi_lite_res_t                   slv_res_o,
  output logic [NumRegs*AxiDataWidth-1:0] reg_q_o,
  output logic [NumRegs-1:0]              reg_wr_o
);

  localparam int unsigned StrbW   = AxiDataWidth / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = idx_width(int'(NumRegs));

`ifdef AXI_LITE_REGFILE_SLVERR_EN
  localparam logic [1:0] OorResp = RESP_SLVERR;
`else
  localparam logic [1:0] OorResp = RESP_OKAY;
`endif

  logic [AxiDataWidth-1:0] regs_reg [NumRegs];
  logic [NumRegs-1:0]      reg_wr_reg;
  logic [NumRegs-1:0]      wr_hit;

  wr_state_e state_reg, state_next;
  logic [1:0] b_resp_reg;

  logic                    r_valid_reg;
  logic [AxiDataWidth-1:0] r_data_reg;
  logic [1:0]              r_resp_reg;

  // AW / W slots
  logic                          aw_full, aw_ready, w_full, w_ready, commit;
  logic [AxiAddrWidth-1:0]       aw_addr;
  logic [StrbW+AxiDataWidth-1:0] w_q;
  logic [StrbW-1:0]              w_strb;
  logic [AxiDataWidth-1:0]       w_data;

  axi_lite_regfile_slot #(.Width(AxiAddrWidth)) i_aw_slot (
    .clk   (clk_i),
    .rst   (rst_i),
    .valid (slv_req_i.aw_valid),
    .data  (slv_req_i.aw.addr),
    .clear (commit),
    .ready (aw_ready),
    .full  (aw_full),
    .q     (aw_addr)
  );

  axi_lite_regfile_slot #(.Width(StrbW + AxiDataWidth)) i_w_slot (
    .clk   (clk_i),
    .rst   (rst_i),
    .valid (slv_req_i.w_valid),
    .data  ({slv_req_i.w.strb, slv_req_i.w.data}),
    .clear (commit),
    .ready (w_ready),
    .full  (w_full),
    .q     (w_q)
  );

  assign {w_strb, w_data} = w_q;

  // Address decode; the in-range test uses the whole word address so aliases are rejected.
  logic [AxiAddrWidth-1:0] aw_word, ar_word;
  logic                    wr_in_range, ar_in_range;
  logic [IdxW-1:0]         wr_idx, ar_idx;

  assign aw_word     = aw_addr >> AddrLsb;
  assign ar_word     = slv_req_i.ar.addr >> AddrLsb;
  assign wr_in_range = aw_word < AxiAddrWidth'(NumRegs);
  assign ar_in_range = ar_word < AxiAddrWidth'(NumRegs);
  assign wr_idx      = aw_word[IdxW-1:0];
  assign ar_idx      = ar_word[IdxW-1:0];

  // A commit needs both halves of the write and a free B channel.
  assign commit = aw_full && w_full && (state_reg != WR_RESP);

  // Write FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= WR_COLLECT;
    else       state_reg <= state_next;
  end

  // Write FSM next state; slots may already be refilled when B is accepted.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WR_COLLECT, WR_COMMIT: begin
        if (commit)                state_next = WR_RESP;
        else if (aw_full && w_full) state_next = WR_COMMIT;
      end
      WR_RESP: begin
        if (slv_req_i.b_ready) state_next = (aw_full && w_full) ? WR_COMMIT : WR_COLLECT;
      end
      default: state_next = WR_COLLECT;
    endcase
  end

  // Byte merge of the write data into the addressed register's current value.
  logic [AxiDataWidth-1:0] wr_merged;
  always_comb begin
    wr_merged = regs_reg[wr_idx];
    for (int b = 0; b < int'(StrbW); b++) begin
      if (w_strb[b]) wr_merged[8*b +: 8] = w_data[8*b +: 8];
    end
  end

  // Register storage and write response, updated on commit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumRegs); i++) regs_reg[i] <= '0;
      b_resp_reg <= RESP_OKAY;
      reg_wr_reg <= '0;
    end else begin
      reg_wr_reg <= wr_hit;
      if (commit) begin
        b_resp_reg <= wr_in_range ? RESP_OKAY : OorResp;
        if (wr_in_range) regs_reg[wr_idx] <= wr_merged;
      end
    end
  end

  // Per-register write strobe and flat output of the register contents.
  for (genvar gi = 0; gi < int'(NumRegs); gi++) begin : g_regs
    assign wr_hit[gi] = commit && wr_in_range && (wr_idx == IdxW'(gi));
    assign reg_q_o[gi*AxiDataWidth +: AxiDataWidth] = regs_reg[gi];
  end

  // Read channel: capture on AR handshake, hold until R is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_reg <= 1'b0;
      r_data_reg  <= '0;
      r_resp_reg  <= RESP_OKAY;
    end else if (slv_req_i.ar_valid && !r_valid_reg) begin
      r_valid_reg <= 1'b1;
      r_data_reg  <= ar_in_range ? regs_reg[ar_idx] : '0;
      r_resp_reg  <= ar_in_range ? RESP_OKAY : OorResp;
    end else if (r_valid_reg && slv_req_i.r_ready) begin
      r_valid_reg <= 1'b0;
    end
  end

  // Response bundle; every field comes straight from a register.
  always_comb begin
    slv_res_o          = '0;
    slv_res_o.aw_ready = aw_ready;
    slv_res_o.w_ready  = w_ready;
    slv_res_o.b.resp   = b_resp_reg;
    slv_res_o.b_valid  = (state_reg == WR_RESP);
    slv_res_o.ar_ready = !r_valid_reg;
    slv_res_o.r.data   = r_data_reg;
    slv_res_o.r.resp   = r_resp_reg;
    slv_res_o.r_valid  = r_valid_reg;
  end

  assign reg_wr_o = reg_wr_reg;

  logic unused_prot;
  assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboard bench for axi_lite_regfile: stimulus pushes expected B/R responses,
// a monitor pops and compares them on each handshake; directed checks cover
// register contents, write pulses, readies and reset behaviour.
module tb_axi_lite_regfile;
  import axi_lite_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  req_t        req;
  res_t        res;
  logic [255:0] reg_q;
  logic [7:0]  reg_wr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic [1:0] exp_b_q [$];
  r_exp_t     exp_r_q [$];

`ifdef AXI_LITE_REGFILE_SLVERR_EN
  localparam logic [1:0] OOR = RESP_SLVERR;
`else
  localparam logic [1:0] OOR = RESP_OKAY;
`endif

  always #5 clk = ~clk;

  axi_lite_regfile dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (req),
    .slv_res_o (res),
    .reg_q_o   (reg_q),
    .reg_wr_o  (reg_wr)
  );

  function automatic logic [31:0] rq(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every B and R handshake against the scoreboard.
  always @(negedge clk) begin
    logic [1:0] eb;
    r_exp_t     er;
    if (!rst) begin
      if (res.b_valid && req.b_ready) begin
        if (exp_b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected: got resp %0d, required no response", res.b.resp);
        end else begin
          eb = exp_b_q.pop_front();
          check("b_resp", {62'd0, res.b.resp}, {62'd0, eb});
          $display("B   resp=%0d", res.b.resp);
        end
      end
      if (res.r_valid && req.r_ready) begin
        if (exp_r_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_unexpected: got data %0h, required no response", res.r.data);
        end else begin
          er = exp_r_q.pop_front();
          check("r_data", {32'd0, res.r.data}, {32'd0, er.data});
          check("r_resp", {62'd0, res.r.resp}, {62'd0, er.resp});
          $display("R   data=%08h resp=%0d", res.r.data, res.r.resp);
        end
      end
    end
  end

  // Issue AW (and optionally W); returns #1 after the last handshake edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp, input bit send_w);
    int   n;
    logic aw_ok, w_ok;
    n = 0;
    exp_b_q.push_back(resp);
    req.aw.addr  = a;
    req.aw_valid = 1'b1;
    if (send_w) begin
      req.w.data  = d;
      req.w.strb  = s;
      req.w_valid = 1'b1;
    end
    while ((req.aw_valid || req.w_valid) && n < 50) begin
      @(negedge clk);
      aw_ok = res.aw_ready;
      w_ok  = res.w_ready;
      @(posedge clk);
      #1;
      if (aw_ok) req.aw_valid = 1'b0;
      if (w_ok)  req.w_valid  = 1'b0;
      n++;
    end
    $display("AW  addr=%08h data=%08h strb=%h", a, d, s);
    if (req.aw_valid || req.w_valid) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: got no handshake, required handshake within 50 cycles");
      req.aw_valid = 1'b0;
      req.w_valid  = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    int     n;
    logic   ok;
    r_exp_t e;
    n = 0;
    ok = 1'b0;
    e.data = d;
    e.resp = resp;
    exp_r_q.push_back(e);
    req.ar.addr  = a;
    req.ar_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = res.ar_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req.ar_valid = 1'b0;
    $display("AR  addr=%08h", a);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: got no handshake, required handshake within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] snap;
    int bcount;

    rst = 1'b1;
    req = '0;
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_aw_ready", res.aw_ready, 1);
    check("rst_w_ready", res.w_ready, 1);
    check("rst_ar_ready", res.ar_ready, 1);
    check("rst_b_valid", res.b_valid, 0);
    check("rst_r_valid", res.r_valid, 0);
    check("rst_b_resp", res.b.resp, 0);
    check("rst_r_data", res.r.data, 0);
    check("rst_reg_q_zero", (reg_q == '0), 1);
    check("rst_reg_wr", reg_wr, 0);
    sync();
    rst = 1'b0;
    sync();

    // Full write to reg 1, AW and W together; exact timing of pulse and update.
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, RESP_OKAY, 1);
    @(negedge clk);
    check("w1_wr_early", reg_wr, 8'h00);
    check("w1_bvalid_early", res.b_valid, 0);
    @(negedge clk);
    check("w1_wr_pulse", reg_wr, 8'h02);
    check("w1_reg1", rq(1), 32'hDEADBEEF);
    check("w1_bvalid", res.b_valid, 1);
    @(negedge clk);
    check("w1_wr_end", reg_wr, 8'h00);
    check("w1_reg0", rq(0), 0);

    // Partial-strobe write, then read back.
    sync();
    axi_write(32'h04, 32'h00001234, 4'h3, RESP_OKAY, 1);
    idle(3);
    check("w2_reg1", rq(1), 32'hDEAD1234);
    axi_read(32'h04, 32'hDEAD1234, RESP_OKAY);
    idle(3);

    // W arrives well before AW: slot stays full, commit follows AW.
    req.w.data  = 32'hA5A5A5A5;
    req.w.strb  = 4'hF;
    req.w_valid = 1'b1;
    @(negedge clk);
    check("w3_w_ready_empty", res.w_ready, 1);
    sync();
    req.w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w3_w_ready_full", res.w_ready, 0);
      check("w3_no_commit", reg_wr, 8'h00);
    end
    sync();
    axi_write(32'h08, 32'hA5A5A5A5, 4'hF, RESP_OKAY, 0);
    @(negedge clk);
    @(negedge clk);
    check("w3_wr_pulse", reg_wr, 8'h04);
    check("w3_reg2", rq(2), 32'hA5A5A5A5);
    check("w3_w_ready_after", res.w_ready, 1);
    idle(3);

    // Out-of-range write and read.
    snap = reg_q;
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, OOR, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("oor_no_pulse", reg_wr, 8'h00);
      check("oor_regs_same", (reg_q == snap), 1);
    end
    sync();
    axi_read(32'h40, 32'h0, OOR);
    idle(3);

    // Read stalled by r_ready while a write to the same register commits.
    req.r_ready = 1'b0;
    @(negedge clk);
    check("r5_idle_aw_ready", res.aw_ready, 1);
    check("r5_idle_ar_ready", res.ar_ready, 1);
    sync();
    exp_b_q.push_back(RESP_OKAY);
    begin
      r_exp_t e;
      e.data = 32'hDEAD1234;
      e.resp = RESP_OKAY;
      exp_r_q.push_back(e);
    end
    req.aw.addr  = 32'h04;
    req.aw_valid = 1'b1;
    req.w.data   = 32'h11111111;
    req.w.strb   = 4'hF;
    req.w_valid  = 1'b1;
    $display("AW  addr=00000004 data=11111111 strb=f");
    sync();
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    req.ar.addr  = 32'h04;
    req.ar_valid = 1'b1;
    $display("AR  addr=00000004");
    sync();
    req.ar_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("r5_r_valid", res.r_valid, 1);
      check("r5_r_data", res.r.data, 32'hDEAD1234);
      check("r5_ar_ready", res.ar_ready, 0);
    end
    check("r5_reg1_new", rq(1), 32'h11111111);
    sync();
    req.r_ready = 1'b1;
    idle(3);

    // Reset with W parked in its slot and B pending.
    req.b_ready = 1'b0;
    axi_write(32'h0C, 32'h55AA55AA, 4'hF, RESP_OKAY, 1);
    idle(2);
    req.w.data  = 32'h12345678;
    req.w.strb  = 4'hF;
    req.w_valid = 1'b1;
    sync();
    req.w_valid = 1'b0;
    @(negedge clk);
    check("rst6_b_valid_pre", res.b_valid, 1);
    check("rst6_w_ready_pre", res.w_ready, 0);
    check("rst6_reg3_pre", rq(3), 32'h55AA55AA);
    #2;
    rst = 1'b1;
    #1;
    check("rst6_b_valid", res.b_valid, 0);
    check("rst6_regs_zero", (reg_q == '0), 1);
    check("rst6_aw_ready", res.aw_ready, 1);
    check("rst6_w_ready", res.w_ready, 1);
    check("rst6_ar_ready", res.ar_ready, 1);
    exp_b_q.delete();
    exp_r_q.delete();
    sync();
    rst = 1'b0;
    req.b_ready = 1'b1;
    bcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res.b_valid) bcount++;
    end
    check("rst6_no_b_after", bcount, 0);
    check("rst6_regs_still_zero", (reg_q == '0), 1);

    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
